rtcomp_vc: RTL and testbench
============================

// Module: rtcomp_vc
// PURPOSE
//  Per-VC route computation for one router input port; successor of the single-context route unit.
//  Head flit computes the output port from destination X/Y. XY or YX dimension order is set by parameter.
//  Route is latched per VC and reused by body/tail flits until the tail. Wormholes on NVC VCs interleave freely.
//  Sits between the input VC buffer read side and the switch/VC allocator.
// PARAMETERS
//  MY_XPOS     0  router X coordinate
//  MY_YPOS     0  router Y coordinate
//  XW          2  destination X field width (bits)
//  YW          2  destination Y field width (bits)
//  NVC         2  virtual channels per input port (>=2)
//  VCW         1  VC index width, clog2(NVC)
//  ROUTE_MODE  0  0 = XY (X first), 1 = YX (Y first)
// PORTS
//  clk       in   1     clock, rising edge
//  rst_      in   1     asynchronous reset, active-high (1 = reset)
//  in_valid  in   1     flit present this cycle
//  in_vc     in   VCW   VC of flit; values >= NVC are illegal
//  in_type   in   2     01 head, 00 body, 10 tail, 11 head+tail (single-flit)
//  in_dstx   in   XW    destination X (sampled on head only)
//  in_dsty   in   YW    destination Y (sampled on head only)
//  out_valid out  1     route result valid
//  out_vc    out  VCW   VC of result (equals in_vc; no VC change)
//  out_port  out  5     one-hot: [0] Local [1] North [2] East [3] South [4] West
//  vc_busy   out  NVC   1 = VC inside a packet (ACTIVE)
//  proto_err out  1     one-cycle pulse on a flit-type protocol violation
// BEHAVIOUR
//  Reset: every VC state IDLE, every latched route 5'b00000, vc_busy=0, out_valid=0, out_port=0, out_vc=0, proto_err=0.
//  Decode (unsigned compare):
//   - XY: dstx>MY_XPOS East; dstx<MY_XPOS West; else dsty>MY_YPOS North; dsty<MY_YPOS South; else Local.
//   - YX: Y compared first, then X.
//   - Exactly one out_port bit is set whenever out_valid=1 and proto_err=0.
//  Per-VC FSM, advances only when in_valid=1 and in_vc selects that VC:
//   - IDLE + head (01): decode, latch route, -> ACTIVE.
//   - IDLE + head+tail (11): decode, do not latch, stay IDLE.
//   - IDLE + body/tail: out_port=0, proto_err=1, stay IDLE.
//   - ACTIVE + body: output latched route, stay ACTIVE.
//   - ACTIVE + tail: output latched route, -> IDLE.
//   - ACTIVE + head/head+tail: proto_err=1; decode new route; 01 relatches and stays ACTIVE; 11 -> IDLE.
//  in_vc>=NVC: no state change, out_port=0, proto_err=1.
//  in_valid=0: no state change, out_valid=0, proto_err=0.
//  No backpressure: one flit per cycle max; stalls are handled upstream by withholding in_valid.
//  vc_busy[v] = (state[v]==ACTIVE), always registered directly from state.
//  Reset asserted mid-packet: all VCs return to IDLE immediately; the next flit on a VC must be a head.
// CONFIGURATION
//  RTCOMP_OUTREG_EN defined:
//   - out_valid/out_vc/out_port/proto_err registered; latency 1 cycle; out_valid and proto_err reset to 0.
//   - FSM and route latch timing are unchanged.
//  RTCOMP_OUTREG_EN undefined:
//   - Outputs are combinational from inputs and state; latency 0.
//   - Route for a head is visible in the same cycle.
//  vc_busy is registered in both builds.
// TESTING
//  Run all scenarios in both builds; with OUTREG_EN, expected outputs shift by 1 cycle.
//  1 XY, MY=(1,1): head vc0 dst(3,0) -> out_port=00100 (E), vc_busy=01; body, then tail -> E, E; vc_busy=00 after tail.
//  2 YX, MY=(1,1): head dst(3,0) -> 01000 (S); head+tail dst(1,1) -> 00001 (L), vc_busy stays 0.
//  3 Interleave: head vc0 dst(0,1) (W), head vc1 dst(1,3) (N), body vc0, tail vc1, tail vc0 -> W,N,W,N,W; vc_busy 01,11,11,01,00.
//  4 Errors: body on IDLE vc1 -> proto_err=1, out_port=0, state unchanged; in_vc=2 with NVC=2 -> proto_err=1.
//  5 Head on ACTIVE vc0 (old route E, new dst (1,0)) -> proto_err=1, out_port=S; following body -> S.
//  6 Assert rst_ while vc0 ACTIVE -> vc_busy=0 asynchronously; body on vc0 after release -> proto_err=1.

Source files
------------

// File: rtl/rtcomp_vc_if.sv
// rtl/rtcomp_vc_if.sv - flit-in / route-out bundle for the per-VC route unit
interface rtcomp_vc_if #(
  parameter int XW  = 2,
  parameter int YW  = 2,
  parameter int NVC = 2,
  parameter int VCW = 1
);
  logic           in_valid;
  logic [VCW-1:0] in_vc;
  logic [1:0]     in_type;
  logic [XW-1:0]  in_dstx;
  logic [YW-1:0]  in_dsty;
  logic           out_valid;
  logic [VCW-1:0] out_vc;
  logic [4:0]     out_port;
  logic [NVC-1:0] vc_busy;
  logic           proto_err;

  modport master (
    output in_valid, in_vc, in_type, in_dstx, in_dsty,
    input  out_valid, out_vc, out_port, vc_busy, proto_err
  );

  modport slave (
    input  in_valid, in_vc, in_type, in_dstx, in_dsty,
    output out_valid, out_vc, out_port, vc_busy, proto_err
  );
endinterface

// File: rtl/rtcomp_vc.sv
// rtl/rtcomp_vc.sv - per-VC XY/YX route computation with latched wormhole routes
// RTCOMP_OUTREG_EN: register out_valid/out_vc/out_port/proto_err (1-cycle latency).
module rtcomp_vc #(
  parameter int MY_XPOS    = 0,
  parameter int MY_YPOS    = 0,
  parameter int XW         = 2,
  parameter int YW         = 2,
  parameter int NVC        = 2,
  parameter int VCW        = 1,
  parameter int ROUTE_MODE = 0
) (
  input logic        clk,
  input logic        rst_,
  rtcomp_vc_if.slave bus
);
  localparam logic [XW-1:0] MY_X = XW'(MY_XPOS);
  localparam logic [YW-1:0] MY_Y = YW'(MY_YPOS);
  localparam logic [4:0] P_L = 5'b00001;
  localparam logic [4:0] P_N = 5'b00010;
  localparam logic [4:0] P_E = 5'b00100;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_W = 5'b10000;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic {VC_IDLE = 1'b0, VC_ACTIVE = 1'b1} vc_state_e;

  vc_state_e      state_q [NVC];
  vc_state_e      state_d [NVC];
  logic [4:0]     route_q [NVC];
  logic [4:0]     route_d [NVC];
  logic [4:0]     new_route;
  logic           res_valid;
  logic [VCW-1:0] res_vc;
  logic [4:0]     res_port;
  logic           res_err;
  logic [NVC-1:0] busy;
  int             vc_idx;

  function automatic logic [4:0] decode(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
    logic [4:0] px;
    logic [4:0] py;
    px = (dx > MY_X) ? P_E : ((dx < MY_X) ? P_W : 5'b00000);
    py = (dy > MY_Y) ? P_N : ((dy < MY_Y) ? P_S : 5'b00000);
    if (ROUTE_MODE == 0) begin
      return (px != 5'b00000) ? px : ((py != 5'b00000) ? py : P_L);
    end
    return (py != 5'b00000) ? py : ((px != 5'b00000) ? px : P_L);
  endfunction

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int v = 0; v < NVC; v++) begin
        state_q[v] <= VC_IDLE;
        route_q[v] <= 5'b00000;
      end
    end else begin
      for (int v = 0; v < NVC; v++) begin
        state_q[v] <= state_d[v];
        route_q[v] <= route_d[v];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    res_valid = 1'b0;
    res_vc    = '0;
    res_port  = 5'b00000;
    res_err   = 1'b0;
    new_route = decode(bus.in_dstx, bus.in_dsty);
    vc_idx    = int'(bus.in_vc);
    if (bus.in_valid) begin
      res_valid = 1'b1;
      res_vc    = bus.in_vc;
      if (vc_idx >= NVC) begin
        res_err = 1'b1;
      end else begin
        for (int v = 0; v < NVC; v++) begin
          if (v == vc_idx) begin
            if (state_q[v] == VC_IDLE) begin
              case (bus.in_type)
                T_HEAD: begin
                  res_port   = new_route;
                  route_d[v] = new_route;
                  state_d[v] = VC_ACTIVE;
                end
                T_BODY, T_TAIL: res_err = 1'b1;
                default: res_port = new_route;
              endcase
            end else begin
              case (bus.in_type)
                T_BODY: res_port = route_q[v];
                T_TAIL: begin
                  res_port   = route_q[v];
                  state_d[v] = VC_IDLE;
                end
                T_HEAD: begin
                  // Malformed wormhole: flag it but adopt the new head so traffic keeps moving.
                  res_err    = 1'b1;
                  res_port   = new_route;
                  route_d[v] = new_route;
                end
                default: begin
                  res_err    = 1'b1;
                  res_port   = new_route;
                  state_d[v] = VC_IDLE;
                end
              endcase
            end
          end
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int v = 0; v < NVC; v++) begin
      busy[v] = (state_q[v] == VC_ACTIVE);
    end
  end

  assign bus.vc_busy = busy;

`ifdef RTCOMP_OUTREG_EN
  logic           out_valid_q;
  logic           out_valid_d;
  logic [VCW-1:0] out_vc_q;
  logic [VCW-1:0] out_vc_d;
  logic [4:0]     out_port_q;
  logic [4:0]     out_port_d;
  logic           proto_err_q;
  logic           proto_err_d;

  always_comb begin
    out_valid_d = res_valid;
    out_vc_d    = res_vc;
    out_port_d  = res_port;
    proto_err_d = res_err;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      out_port_q  <= 5'b00000;
      proto_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_vc_q    <= out_vc_d;
      out_port_q  <= out_port_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vc    = out_vc_q;
  assign bus.out_port  = out_port_q;
  assign bus.proto_err = proto_err_q;
`else
  assign bus.out_valid = res_valid;
  assign bus.out_vc    = res_vc;
  assign bus.out_port  = res_port;
  assign bus.proto_err = res_err;
`endif
endmodule

// File: tb/tb_rtcomp_vc.sv
// tb/tb_rtcomp_vc.sv - directed checks of rtcomp_vc, XY and YX instances side by side
module tb_rtcomp_vc;
  localparam int XW = 2, YW = 2, NVC = 2, VCW = 2;
  localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;
  localparam logic [4:0] L = 5'b00001, N = 5'b00010, E = 5'b00100, S = 5'b01000, W = 5'b10000;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic           xy_valid, yx_valid, xy_err, yx_err;
  logic [VCW-1:0] xy_vc;
  logic [4:0]     xy_port, yx_port;
  logic [NVC-1:0] xy_busy, yx_busy;

  always #5 clk = ~clk;

  rtcomp_vc_if #(.XW(XW), .YW(YW), .NVC(NVC), .VCW(VCW)) if_xy ();
  rtcomp_vc_if #(.XW(XW), .YW(YW), .NVC(NVC), .VCW(VCW)) if_yx ();

  rtcomp_vc #(.MY_XPOS(1), .MY_YPOS(1), .XW(XW), .YW(YW), .NVC(NVC), .VCW(VCW), .ROUTE_MODE(0))
    dut_xy (.clk(clk), .rst_(rst_), .bus(if_xy.slave));
  rtcomp_vc #(.MY_XPOS(1), .MY_YPOS(1), .XW(XW), .YW(YW), .NVC(NVC), .VCW(VCW), .ROUTE_MODE(1))
    dut_yx (.clk(clk), .rst_(rst_), .bus(if_yx.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [VCW-1:0] vc, input logic [1:0] ty,
                       input logic [XW-1:0] x, input logic [YW-1:0] y);
    if_xy.in_valid = v; if_xy.in_vc = vc; if_xy.in_type = ty; if_xy.in_dstx = x; if_xy.in_dsty = y;
    if_yx.in_valid = v; if_yx.in_vc = vc; if_yx.in_type = ty; if_yx.in_dstx = x; if_yx.in_dsty = y;
  endtask

  task automatic sample_out();
    xy_valid = if_xy.out_valid; xy_vc = if_xy.out_vc; xy_port = if_xy.out_port; xy_err = if_xy.proto_err;
    yx_valid = if_yx.out_valid; yx_port = if_yx.out_port; yx_err = if_yx.proto_err;
  endtask

  // Entered and left at posedge+1; outputs sampled where each build presents them.
  task automatic step(input logic v, input logic [VCW-1:0] vc, input logic [1:0] ty,
                      input logic [XW-1:0] x, input logic [YW-1:0] y);
    drive(v, vc, ty, x, y);
`ifdef RTCOMP_OUTREG_EN
    @(posedge clk); #1;
    sample_out();
`else
    #3;
    sample_out();
    @(posedge clk); #1;
`endif
    xy_busy = if_xy.vc_busy;
    yx_busy = if_yx.vc_busy;
    drive(1'b0, '0, BODY, '0, '0);
  endtask

  initial begin
    drive(1'b0, '0, BODY, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
    sample_out();
    check("rst_valid", {31'd0, xy_valid}, 32'd0);
    check("rst_port", {27'd0, xy_port}, 32'd0);
    check("rst_vc", {30'd0, xy_vc}, 32'd0);
    check("rst_err", {31'd0, xy_err}, 32'd0);
    check("rst_busy", {30'd0, if_xy.vc_busy}, 32'd0);

    // XY packet on vc0 toward East, YX instance sees South
    step(1'b1, 2'd0, HEAD, 2'd3, 2'd0);
    check("s1_head_valid", {31'd0, xy_valid}, 32'd1);
    check("s1_head_port", {27'd0, xy_port}, {27'd0, E});
    check("s1_head_err", {31'd0, xy_err}, 32'd0);
    check("s1_head_busy", {30'd0, xy_busy}, 32'd1);
    check("s2_yx_head_port", {27'd0, yx_port}, {27'd0, S});
    check("s2_yx_head_busy", {30'd0, yx_busy}, 32'd1);
    step(1'b1, 2'd0, BODY, 2'd0, 2'd0);
    check("s1_body_port", {27'd0, xy_port}, {27'd0, E});
    check("s1_body_busy", {30'd0, xy_busy}, 32'd1);
    check("s2_yx_body_port", {27'd0, yx_port}, {27'd0, S});
    step(1'b1, 2'd0, TAIL, 2'd0, 2'd0);
    check("s1_tail_port", {27'd0, xy_port}, {27'd0, E});
    check("s1_tail_busy", {30'd0, xy_busy}, 32'd0);

    step(1'b1, 2'd0, HT, 2'd1, 2'd1);
    check("s2_ht_xy_port", {27'd0, xy_port}, {27'd0, L});
    check("s2_ht_yx_port", {27'd0, yx_port}, {27'd0, L});
    check("s2_ht_yx_err", {31'd0, yx_err}, 32'd0);
    check("s2_ht_yx_busy", {30'd0, yx_busy}, 32'd0);
    step(1'b1, 2'd1, HT, 2'd3, 2'd3);
    check("s2_ht_xy_corner", {27'd0, xy_port}, {27'd0, E});
    check("s2_ht_yx_corner", {27'd0, yx_port}, {27'd0, N});

    // Interleaved wormholes on vc0 and vc1
    step(1'b1, 2'd0, HEAD, 2'd0, 2'd1);
    check("s3_h0_port", {27'd0, xy_port}, {27'd0, W});
    check("s3_h0_busy", {30'd0, xy_busy}, 32'd1);
    step(1'b1, 2'd1, HEAD, 2'd1, 2'd3);
    check("s3_h1_port", {27'd0, xy_port}, {27'd0, N});
    check("s3_h1_vc", {30'd0, xy_vc}, 32'd1);
    check("s3_h1_busy", {30'd0, xy_busy}, 32'd3);
    step(1'b1, 2'd0, BODY, 2'd3, 2'd3);
    check("s3_b0_port", {27'd0, xy_port}, {27'd0, W});
    check("s3_b0_busy", {30'd0, xy_busy}, 32'd3);
    step(1'b1, 2'd1, TAIL, 2'd0, 2'd0);
    check("s3_t1_port", {27'd0, xy_port}, {27'd0, N});
    check("s3_t1_busy", {30'd0, xy_busy}, 32'd1);
    step(1'b1, 2'd0, TAIL, 2'd0, 2'd0);
    check("s3_t0_port", {27'd0, xy_port}, {27'd0, W});
    check("s3_t0_busy", {30'd0, xy_busy}, 32'd0);

    // Protocol errors
    step(1'b1, 2'd1, BODY, 2'd3, 2'd0);
    check("s4_idle_body_err", {31'd0, xy_err}, 32'd1);
    check("s4_idle_body_port", {27'd0, xy_port}, 32'd0);
    check("s4_idle_body_busy", {30'd0, xy_busy}, 32'd0);
    step(1'b1, 2'd2, HEAD, 2'd3, 2'd0);
    check("s4_badvc_err", {31'd0, xy_err}, 32'd1);
    check("s4_badvc_port", {27'd0, xy_port}, 32'd0);
    check("s4_badvc_busy", {30'd0, xy_busy}, 32'd0);
    step(1'b0, 2'd0, HEAD, 2'd3, 2'd0);
    check("s4_idle_valid", {31'd0, xy_valid}, 32'd0);
    check("s4_idle_err", {31'd0, xy_err}, 32'd0);

    // Head on an ACTIVE VC replaces the route
    step(1'b1, 2'd0, HEAD, 2'd3, 2'd0);
    check("s5_h_port", {27'd0, xy_port}, {27'd0, E});
    step(1'b1, 2'd0, HEAD, 2'd1, 2'd0);
    check("s5_rehead_err", {31'd0, xy_err}, 32'd1);
    check("s5_rehead_port", {27'd0, xy_port}, {27'd0, S});
    check("s5_rehead_busy", {30'd0, xy_busy}, 32'd1);
    step(1'b1, 2'd0, BODY, 2'd3, 2'd3);
    check("s5_body_port", {27'd0, xy_port}, {27'd0, S});
    check("s5_body_err", {31'd0, xy_err}, 32'd0);

    // Asynchronous reset while vc0 is ACTIVE
    #1 rst_ = 1'b1;
    #1;
    check("s6_async_busy", {30'd0, if_xy.vc_busy}, 32'd0);
    #1 rst_ = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 2'd0, BODY, 2'd0, 2'd0);
    check("s6_body_err", {31'd0, xy_err}, 32'd1);
    check("s6_body_port", {27'd0, xy_port}, 32'd0);
    check("s6_body_busy", {30'd0, xy_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
